sync_asym_width_fifo: RTL
=========================

// Module: sync_asym_width_fifo
// PURPOSE
//  Single-clock asymmetric-width FIFO: narrow write port, wide read port, any integer ratio.
//  Packs RATIO consecutive write words into one storage entry. Adds partial-word flush,
//  overflow/underflow flags and hysteretic programmable full/empty thresholds.
//  Drop-in successor for the fixed 1:2 FIFO in the I2C_FIFO data path and its demo checker.
// PARAMETERS
//  DATA_WIDTH   16           narrow write word width (bits)
//  RATIO        2            read width = DATA_WIDTH*RATIO; >=1 (1 = symmetric)
//  DEPTH        512          wide storage entries; power of 2, >=4
//  PACK_ORDER   "MSB_FIRST"  first written word lands in top lane; "LSB_FIRST" = bottom lane
//  OUTPUT_REG   0            1 = extra rdata register, +1 cycle read latency
//  PAD_VALUE    0            DATA_WIDTH fill for unwritten lanes on flush
//  PF_ASSERT    384          prog_full_o sets when count >= PF_ASSERT
//  PF_NEGATE    320          prog_full_o clears when count < PF_NEGATE (PF_NEGATE <= PF_ASSERT)
//  PE_ASSERT    8            prog_empty_o sets when count <= PE_ASSERT
//  PE_NEGATE    16           prog_empty_o clears when count > PE_NEGATE (PE_NEGATE >= PE_ASSERT)
// PORTS
//  clk_i         in   1                  single clock, all logic on rising edge
//  rst_i         in   1                  synchronous, active-high reset
//  wr_en_i       in   1                  write request
//  wdata         in   DATA_WIDTH         write data
//  flush_i       in   1                  commit partially packed word, padded
//  rd_en_i       in   1                  read request
//  rdata         out  DATA_WIDTH*RATIO   read data
//  rd_valid_o    out  1                  rdata valid, 1-cycle pulse per accepted read
//  full_o        out  1                  count == DEPTH
//  empty_o       out  1                  count == 0 (partial packer content not visible)
//  prog_full_o   out  1                  hysteretic threshold flag
//  prog_empty_o  out  1                  hysteretic threshold flag
//  overflow_o    out  1                  1-cycle pulse: write/flush rejected
//  underflow_o   out  1                  1-cycle pulse: read rejected
//  count_o       out  clog2(DEPTH)+1     committed wide entries
//  rst_busy      out  1                  high during rst_i and 2 cycles after
// BEHAVIOUR
//  Reset: all outputs 0 except empty_o=1, prog_empty_o=1; lane counter, pointers cleared.
//  Reset mid-operation: all contents discarded next cycle; no rd_valid_o after reset edge.
//  rst_busy high: wr_en_i, rd_en_i, flush_i ignored, no flags raised.
//  Write accepted iff wr_en_i & ~full_o & ~rst_busy; else overflow_o pulses next cycle.
//   Accepted word fills lane lane_cnt (0..RATIO-1), lane_cnt increments.
//   On lane RATIO-1: entry committed at wr_ptr, lane_cnt wraps to 0, count +1 next cycle.
//   full_o rejects writes even when packer lanes are free.
//  Flush: flush_i with lane_cnt>0 and ~full_o commits packer, unwritten lanes = PAD_VALUE.
//   flush_i with lane_cnt==0: no-op. flush_i while full_o: ignored, overflow_o pulses.
//   flush_i + accepted wr_en_i same cycle: word included first, then commit (one entry).
//  Read accepted iff rd_en_i & ~empty_o & ~rst_busy; else underflow_o pulses next cycle.
//   rdata/rd_valid_o at t+1 (OUTPUT_REG=0) or t+2 (OUTPUT_REG=1).
//   rdata holds last value between reads.
//  Simultaneous commit+read: count unchanged; at count==0 the read is rejected (underflow).
//  Flags/count registered, reflect state after the current edge.
//   Commit at t -> empty_o low at t+1.
//  Pointers wrap modulo DEPTH; count saturates by construction, never exceeds DEPTH.
//  PF/PE hysteresis evaluated on next count each cycle; sets take precedence if both apply.
// STRUCTURE
//  fifo_pkg: clog2 function, PACK_ORDER encodings, parameter legality checks.
//  Sub-module sync_fifo_ram: simple dual-port, DEPTH x (DATA_WIDTH*RATIO), 1-cycle read.
//  Top: packer + lane counter, pointer/count control, flag/hysteresis logic, output register.
// TESTING (DATA_WIDTH=16, RATIO=2, DEPTH=8, PF 6/4, PE 1/2, PAD 0)
//  Fill:
//   wr 0x0001..0x0010 -> full_o=1 after 16th write, count_o=8.
//   17th write -> overflow_o pulse, contents unchanged.
//  Drain:
//   8 reads -> rdata 0x00010002, 0x00030004 .. 0x000F0010, one rd_valid_o each.
//   9th read -> underflow_o pulse.
//  Flush:
//   wr 0xAAAA, flush -> rdata 0xAAAA0000.
//   LSB_FIRST build -> 0x0000AAAA.
//   Flush with empty packer -> count unchanged.
//  Hysteresis:
//   count 0->6 -> prog_full_o sets at 6.
//   Drain to 4 -> still 1; at 3 -> clears.
//   prog_empty_o clears at 3, resets at 1.
//  Concurrency:
//   count=3, commit+read same cycle -> count stays 3, rdata correct.
//   At full_o, wr+rd -> write rejected, count 7.
//  Reset:
//   count=5, rst_i 1 cycle -> count_o 0, empty_o 1, rst_busy high 3 cycles.
//   Write during busy ignored.
//  OUTPUT_REG=1 rerun of Drain -> all rd_valid_o one cycle later, same data.

Source files
------------

// File: rtl/sync_asym_width_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sync_asym_width_fifo_pkg
// Description : Shared helpers for the asymmetric-width FIFO: ceil-log2,
//               lane packing order encoding and parameter legality check.
// Contents    : clog2()        - ceil(log2(value)), clog2(1) = 0
//               pack_order_e   - lane packing order
//               params_legal() - 1 when a parameter set is usable
// Revision    : 1.0 - initial release
// ============================================================================
package sync_asym_width_fifo_pkg;

    typedef enum logic {
        PACK_MSB_FIRST = 1'b0,
        PACK_LSB_FIRST = 1'b1
    } pack_order_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit params_legal(input int dw, input int ratio, input int depth,
                                        input int pf_a, input int pf_n,
                                        input int pe_a, input int pe_n);
        return (dw >= 1) && (ratio >= 1) && (depth >= 4) &&
               ((depth & (depth - 1)) == 0) && (pf_n <= pf_a) && (pe_n >= pe_a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_asym_width_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_asym_width_fifo_ram
// Description : Simple dual-port storage, one write port and one registered
//               read port (data valid one cycle after the read strobe).
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (read register only)
//               i_we     - write strobe,  i_waddr / i_wdata
//               i_re     - read strobe,   i_raddr
//               o_rdata  - registered read data, holds between reads
// Revision    : 1.0 - initial release
// ============================================================================
module sync_asym_width_fifo_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array carries no reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sync_asym_width_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_asym_width_fifo
// Description : Single-clock FIFO with a narrow write port and a wide read
//               port. RATIO narrow words are packed into one stored entry;
//               a flush commits a partially packed entry with padded lanes.
// Ports       : clk_i, rst_i           - clock, synchronous active-high reset
//               wr_en_i, wdata         - narrow write
//               flush_i                - commit partial packer content
//               rd_en_i                - wide read request
//               rdata, rd_valid_o      - wide read data and valid pulse
//               full_o, empty_o        - committed-entry full / empty
//               prog_full_o/empty_o    - hysteretic threshold flags
//               overflow_o/underflow_o - rejected write/flush or read pulse
//               count_o                - committed wide entries
//               rst_busy               - high for 3 cycles from a reset edge
// Revision    : 1.0 - initial release
// ============================================================================
module sync_asym_width_fifo
    import sync_asym_width_fifo_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    RATIO      = 2,
    parameter int                    DEPTH      = 512,
    parameter                        PACK_ORDER = "MSB_FIRST",
    parameter int                    OUTPUT_REG = 0,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
    parameter int                    PF_ASSERT  = 384,
    parameter int                    PF_NEGATE  = 320,
    parameter int                    PE_ASSERT  = 8,
    parameter int                    PE_NEGATE  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          flush_i,
    input  logic                          rd_en_i,
    output logic [DATA_WIDTH*RATIO-1:0]   rdata,
    output logic                          rd_valid_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          prog_full_o,
    output logic                          prog_empty_o,
    output logic                          overflow_o,
    output logic                          underflow_o,
    output logic [clog2(DEPTH):0]         count_o,
    output logic                          rst_busy
);

    localparam int c_WW = DATA_WIDTH * RATIO;
    localparam int c_AW = clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_LW = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;

    localparam pack_order_e     c_ORDER     = (PACK_ORDER == "LSB_FIRST") ? PACK_LSB_FIRST
                                                                          : PACK_MSB_FIRST;
    localparam logic [c_WW-1:0] c_PAD_WORD  = {RATIO{PAD_VALUE}};
    localparam logic [c_LW-1:0] c_LAST_LANE = c_LW'(RATIO - 1);
    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_PF_A      = c_CW'(PF_ASSERT);
    localparam logic [c_CW-1:0] c_PF_N      = c_CW'(PF_NEGATE);
    localparam logic [c_CW-1:0] c_PE_A      = c_CW'(PE_ASSERT);
    localparam logic [c_CW-1:0] c_PE_N      = c_CW'(PE_NEGATE);

    if (!params_legal(DATA_WIDTH, RATIO, DEPTH, PF_ASSERT, PF_NEGATE, PE_ASSERT, PE_NEGATE))
    begin : g_bad_params
        $error("sync_asym_width_fifo: illegal parameter combination");
    end

    // Bit offset of a lane inside the wide word; lane 0 is the first word written.
    function automatic int lane_lsb(input int lane);
        return ((c_ORDER == PACK_MSB_FIRST) ? (RATIO - 1 - lane) : lane) * DATA_WIDTH;
    endfunction

    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count, w_count_next;
    logic [c_LW-1:0] r_lane;
    logic [c_WW-1:0] r_pack, w_pack_next;
    logic [c_WW-1:0] w_ram_rdata;
    logic [1:0]      r_busy_cnt;
    logic            r_busy, r_full, r_empty, r_pf, r_pe, r_ovf, r_unf, r_vld1;
    logic            w_wr_acc, w_flush_ok, w_rd_acc, w_commit;

    assign w_wr_acc   = wr_en_i & ~r_full & ~r_busy;
    assign w_flush_ok = flush_i & ~r_full & ~r_busy;
    assign w_rd_acc   = rd_en_i & ~r_empty & ~r_busy;

    // A flush together with an accepted write includes that word before committing.
    assign w_commit = (w_wr_acc & (r_lane == c_LAST_LANE)) |
                      (w_flush_ok & ((r_lane != '0) | w_wr_acc));

    // Unwritten lanes of r_pack always hold PAD_VALUE, so the commit data is
    // simply the packer with the current word merged in.
    always_comb begin
        w_pack_next = r_pack;
        for (int i = 0; i < RATIO; i++) begin
            if (w_wr_acc && (r_lane == c_LW'(i))) begin
                w_pack_next[lane_lsb(i) +: DATA_WIDTH] = wdata;
            end
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_commit && !w_rd_acc) begin
            w_count_next = r_count + c_CW'(1);
        end else if (!w_commit && w_rd_acc) begin
            w_count_next = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lane     <= '0;
            r_pack     <= c_PAD_WORD;
            r_busy     <= 1'b1;
            r_busy_cnt <= 2'd2;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_pf       <= 1'b0;
            r_pe       <= 1'b1;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_vld1     <= 1'b0;
        end else begin
            if (r_busy_cnt != 2'd0) begin
                r_busy_cnt <= r_busy_cnt - 2'd1;
            end
            r_busy  <= (r_busy_cnt != 2'd0);
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH);
            r_empty <= (w_count_next == '0);
            r_ovf   <= ~r_busy & r_full & (wr_en_i | flush_i);
            r_unf   <= ~r_busy & r_empty & rd_en_i;
            r_vld1  <= w_rd_acc;

            if (w_commit) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
                r_lane   <= '0;
                r_pack   <= c_PAD_WORD;
            end else if (w_wr_acc) begin
                r_lane   <= r_lane + c_LW'(1);
                r_pack   <= w_pack_next;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end

            // Set conditions win over clear conditions.
            if (w_count_next >= c_PF_A) begin
                r_pf <= 1'b1;
            end else if (w_count_next < c_PF_N) begin
                r_pf <= 1'b0;
            end
            if (w_count_next <= c_PE_A) begin
                r_pe <= 1'b1;
            end else if (w_count_next > c_PE_N) begin
                r_pe <= 1'b0;
            end
        end
    end

    // Read and write addresses never collide: a commit needs ~full and a read
    // needs ~empty, so both active means wr_ptr != rd_ptr.
    sync_asym_width_fifo_ram #(
        .WIDTH  (c_WW),
        .DEPTH  (DEPTH),
        .ADDR_W (c_AW)
    ) u_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_we    (w_commit),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_pack_next),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic            r_vld2;
        logic [c_WW-1:0] r_rdata_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_vld2    <= 1'b0;
                r_rdata_q <= '0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_rdata_q <= w_ram_rdata;
                end
            end
        end
        assign rdata      = r_rdata_q;
        assign rd_valid_o = r_vld2;
    end else begin : g_out_direct
        assign rdata      = w_ram_rdata;
        assign rd_valid_o = r_vld1;
    end

    assign full_o       = r_full;
    assign empty_o      = r_empty;
    assign prog_full_o  = r_pf;
    assign prog_empty_o = r_pe;
    assign overflow_o   = r_ovf;
    assign underflow_o  = r_unf;
    assign count_o      = r_count;
    assign rst_busy     = r_busy;

endmodule
`default_nettype wire
